// File: rtl/wb_timer_irq.sv
// Wishbone classic timer with compare-match level interrupt; ack 1 cycle after request, read data registered with ack.
// No backpressure: every request is acked exactly once, a held strobe is served every 2nd cycle.
module wb_timer_irq #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRE_W   = 16,
  parameter logic [31:0] CMP_RST = 32'h1FFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_COUNT = 3'd1;
  localparam logic [2:0] A_CMP   = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_PRE   = 3'd4;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [2:0]       ctrl_q, ctrl_d;  // {IE, AR, EN}
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] psc_q, psc_d;
  logic             pend_q, pend_d;

  logic        req, wr, tick, match;
  logic [2:0]  adr;
  logic [31:0] rd_word, wmerge;
  logic        unused_adr;

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    adr     = wb_adr_i[4:2];
    req     = wb_cyc_i & wb_stb_i & ~ack_q;
    wr      = req & wb_we_i;

    case (adr)
      A_CTRL:  rd_word = {29'b0, ctrl_q};
      A_COUNT: rd_word = 32'(count_q);
      A_CMP:   rd_word = 32'(cmp_q);
      A_STAT:  rd_word = {31'b0, pend_q};
      A_PRE:   rd_word = 32'(pre_q);
      default: rd_word = 32'h0;
    endcase
    // Merging onto the addressed register's current value keeps unselected lanes intact.
    wmerge  = merge_bytes(rd_word, wb_dat_i, wb_sel_i);

    ack_d   = req;
    dat_d   = (req && !wb_we_i) ? rd_word : 32'h0;

    tick    = 1'b0;
    psc_d   = psc_q;
    if (!ctrl_q[0]) begin
      psc_d = '0;
    end else if (psc_q == pre_q) begin
      psc_d = '0;
      tick  = 1'b1;
    end else begin
      psc_d = psc_q + PRE_W'(1);
    end

    match   = tick && (count_q == cmp_q);
    count_d = count_q;
    if (tick) count_d = (match && ctrl_q[1]) ? '0 : count_q + CNT_W'(1);

    pend_d  = pend_q;
    if (wr && adr == A_STAT && wb_sel_i[0] && wb_dat_i[0]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;

    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    pre_d   = pre_q;
    // Bus writes are applied last so they override the tick update.
    if (wr) begin
      case (adr)
        A_CTRL:  ctrl_d  = wmerge[2:0];
        A_COUNT: count_d = wmerge[CNT_W-1:0];
        A_CMP:   cmp_d   = wmerge[CNT_W-1:0];
        A_PRE: begin
          pre_d = wmerge[PRE_W-1:0];
          psc_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      ctrl_q  <= 3'b0;
      count_q <= '0;
      cmp_q   <= CMP_RST[CNT_W-1:0];
      pre_q   <= '0;
      psc_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      psc_q   <= psc_d;
      pend_q  <= pend_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = pend_q & ctrl_q[2];

endmodule
